// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction fetches and loads the IF/ID register.
// One returned instruction is buffered so that a stall never drops imem data.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_enable,
    input  logic        ifid_enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] D_instruction,
    output logic [31:0] D_pc_plus4,
    output logic        D_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_buf, hold_buf_n;
    logic [31:0] d_instr_n, d_pc4_n;
    logic        d_valid_n;
    logic        advance;
    logic        halt_seen;
    logic [31:0] pc_plus4;

    assign advance   = pc_enable & ifid_enable;
    assign pc_plus4  = pc + 32'd4;
    assign halt_seen = D_valid && (D_instruction[31:26] == 6'h3f);

    assign imem_req  = (state == FETCH) && !reset;
    assign imem_addr = pc;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_buf_n = hold_buf;
        d_instr_n  = D_instruction;
        d_pc4_n    = D_pc_plus4;
        d_valid_n  = D_valid;
        if (state != HALTED) begin
            if (branch_taken) begin
                pc_n      = branch_target;
                d_instr_n = NOP_INSTR;
                d_valid_n = 1'b0;
                state_n   = FETCH;
            end else if (halt_seen) begin
                state_n = HALTED;
            end else if (state == FETCH) begin
                if (imem_ready && advance) begin
                    d_instr_n = imem_rdata;
                    d_pc4_n   = pc_plus4;
                    d_valid_n = 1'b1;
                    pc_n      = pc_plus4;
                end else if (imem_ready) begin
                    hold_buf_n = imem_rdata;
                    state_n    = HOLD;
                end else if (ifid_enable) begin
                    d_instr_n = NOP_INSTR;
                    d_valid_n = 1'b0;
                end
            end else if (advance) begin
                // HOLD: release the buffered instruction
                d_instr_n = hold_buf;
                d_pc4_n   = pc_plus4;
                d_valid_n = 1'b1;
                pc_n      = pc_plus4;
                state_n   = FETCH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            hold_buf      <= 32'h0;
            D_instruction <= NOP_INSTR;
            D_pc_plus4    <= 32'h0;
            D_valid       <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            hold_buf      <= hold_buf_n;
            D_instruction <= d_instr_n;
            D_pc_plus4    <= d_pc4_n;
            D_valid       <= d_valid_n;
            halted        <= (state_n == HALTED);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: advance, wait states, hold,
// branch redirect, halt freeze and PC wrap.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        pc_enable;
    logic        ifid_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] D_instruction;
    logic [31:0] D_pc_plus4;
    logic        D_valid;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pc_enable    (pc_enable),
        .ifid_enable  (ifid_enable),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .D_instruction(D_instruction),
        .D_pc_plus4   (D_pc_plus4),
        .D_valid      (D_valid),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic ifid(input string tag,
                        input logic [31:0] instr,
                        input logic [31:0] pc4,
                        input logic        vld);
        check({tag, ".instr"}, D_instruction, instr);
        check({tag, ".pc4"}, D_pc_plus4, pc4);
        check({tag, ".valid"}, {31'b0, D_valid}, {31'b0, vld});
    endtask

    task automatic enables(input logic p, input logic f);
        pc_enable   = p;
        ifid_enable = f;
    endtask

    initial begin
        reset         = 1'b1;
        enables(1'b1, 1'b1);
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b1;
        imem_rdata    = 32'h0;
        tick();

        // reset state
        check("rst.req", {31'b0, imem_req}, 32'd0);
        check("rst.addr", imem_addr, 32'h100);
        check("rst.halted", {31'b0, halted}, 32'd0);
        ifid("rst", 32'h0, 32'h0, 1'b0);

        // back-to-back fetch, zero wait states
        reset = 1'b0;
        #1;
        check("t1.req", {31'b0, imem_req}, 32'd1);
        check("t1.addr0", imem_addr, 32'h100);
        imem_rdata = 32'h2001_0001;
        tick();
        check("t1.addr1", imem_addr, 32'h104);
        ifid("t1a", 32'h2001_0001, 32'h104, 1'b1);
        imem_rdata = 32'h2002_0002;
        tick();
        check("t1.addr2", imem_addr, 32'h108);
        ifid("t1b", 32'h2002_0002, 32'h108, 1'b1);

        // wait states at 0x200 produce bubbles
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        check("t2.addr", imem_addr, 32'h200);
        check("t2.bv", {31'b0, D_valid}, 32'd0);
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        tick();
        check("t2.w1addr", imem_addr, 32'h200);
        ifid("t2.w1", 32'h0, 32'h108, 1'b0);
        tick();
        check("t2.w2addr", imem_addr, 32'h200);
        ifid("t2.w2", 32'h0, 32'h108, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0022_1820;
        tick();
        check("t2.addr3", imem_addr, 32'h204);
        ifid("t2.ld", 32'h0022_1820, 32'h204, 1'b1);

        // ready during stall -> HOLD, then release
        enables(1'b0, 1'b0);
        imem_rdata = 32'h8C41_0004;
        tick();
        check("t3.req0", {31'b0, imem_req}, 32'd0);
        ifid("t3.h0", 32'h0022_1820, 32'h204, 1'b1);
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        ifid("t3.h1", 32'h0022_1820, 32'h204, 1'b1);
        enables(1'b1, 1'b0);
        tick();
        check("t3.mis.req", {31'b0, imem_req}, 32'd0);
        ifid("t3.h2", 32'h0022_1820, 32'h204, 1'b1);
        enables(1'b1, 1'b1);
        imem_ready = 1'b0;
        tick();
        ifid("t3.rel", 32'h8C41_0004, 32'h208, 1'b1);
        check("t3.addr", imem_addr, 32'h208);
        check("t3.req1", {31'b0, imem_req}, 32'd1);

        // branch out of HOLD discards the buffer
        enables(1'b0, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        check("t4.hreq", {31'b0, imem_req}, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h400;
        tick();
        check("t4.addr", imem_addr, 32'h400);
        check("t4.req", {31'b0, imem_req}, 32'd1);
        ifid("t4.flush", 32'h0, 32'h208, 1'b0);
        branch_taken = 1'b0;
        enables(1'b1, 1'b1);
        imem_rdata = 32'h2222_2222;
        tick();
        ifid("t4.ld", 32'h2222_2222, 32'h404, 1'b1);
        // branch while waiting
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        tick();
        check("t4.waddr", imem_addr, 32'h500);
        check("t4.wv", {31'b0, D_valid}, 32'd0);
        // data returned with branch is dropped
        imem_ready    = 1'b1;
        imem_rdata    = 32'h3333_3333;
        branch_target = 32'h600;
        tick();
        check("t4.daddr", imem_addr, 32'h600);
        ifid("t4.drop", 32'h0, 32'h404, 1'b0);

        // PC wrap
        branch_target = 32'hFFFF_FFFC;
        tick();
        check("t6.addr", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        imem_rdata   = 32'h2003_0003;
        tick();
        check("t6.wrap", imem_addr, 32'h0);
        ifid("t6", 32'h2003_0003, 32'h0, 1'b1);

        // halt
        imem_rdata = 32'hFC00_0000;
        tick();
        ifid("t5.ld", 32'hFC00_0000, 32'h4, 1'b1);
        check("t5.h0", {31'b0, halted}, 32'd0);
        imem_rdata = 32'h2004_0004;
        tick();
        check("t5.h1", {31'b0, halted}, 32'd1);
        check("t5.req", {31'b0, imem_req}, 32'd0);
        check("t5.addr", imem_addr, 32'h4);
        ifid("t5.frz", 32'hFC00_0000, 32'h4, 1'b1);
        branch_taken  = 1'b1;
        branch_target = 32'h700;
        tick();
        branch_taken = 1'b0;
        check("t5.baddr", imem_addr, 32'h4);
        check("t5.bh", {31'b0, halted}, 32'd1);
        check("t5.breq", {31'b0, imem_req}, 32'd0);
        reset = 1'b1;
        tick();
        check("t5.raddr", imem_addr, 32'h100);
        check("t5.rh", {31'b0, halted}, 32'd0);
        check("t5.rreq", {31'b0, imem_req}, 32'd0);
        ifid("t5.r", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        #1;
        check("t5.req1", {31'b0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
